// File: rtl/cpu_step_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cpu_step_ctrl
// Brief    : Run/step controller that turns debounced step-button and
//            run-switch levels into one-cycle clock-enable pulses for the
//            core, frozen by a halt request. Optional pulse counter is
//            built only when STEP_COUNT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module cpu_step_ctrl #(
    parameter int RUN_DIV = 25_000_000,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             step_in,
    input  logic             run_in,
    input  logic             halt_in,
    output logic             cpu_en,
    output logic [1:0]       mode,
    output logic [CNT_W-1:0] step_count
);

    localparam int c_PRESC_W = $clog2(RUN_DIV);
    localparam logic [c_PRESC_W-1:0] c_TERM     = c_PRESC_W'(RUN_DIV - 1);
    localparam logic [c_PRESC_W-1:0] c_PRE_TERM = c_PRESC_W'(RUN_DIV - 2);

    localparam logic [1:0] c_S_IDLE = 2'b00;
    localparam logic [1:0] c_S_RUN  = 2'b01;
    localparam logic [1:0] c_S_HALT = 2'b10;

    logic [1:0]           r_state;
    logic [1:0]           w_state_next;
    logic                 r_step_q;
    logic [c_PRESC_W-1:0] r_presc;
    logic                 r_cpu_en;
    logic                 w_step_rise;
    logic                 w_pulse;
    logic                 w_presc_clr;
    logic                 w_presc_inc;

    assign w_step_rise = step_in & ~r_step_q;

    always_comb begin
        w_state_next = r_state;
        w_pulse      = 1'b0;
        w_presc_clr  = 1'b0;
        w_presc_inc  = 1'b0;
        case (r_state)
            c_S_IDLE: begin
                if (halt_in) begin
                    w_state_next = c_S_HALT;
                end else if (run_in) begin
                    w_state_next = c_S_RUN;
                    w_presc_clr  = 1'b1;
                end else if (w_step_rise) begin
                    w_pulse = 1'b1;
                end
            end
            c_S_RUN: begin
                if (halt_in) begin
                    w_state_next = c_S_HALT;
                    w_presc_clr  = 1'b1;
                end else if (!run_in) begin
                    w_state_next = c_S_IDLE;
                    w_presc_clr  = 1'b1;
                end else begin
                    // The entry edge counts as the first prescaler tick, so the
                    // pulse is registered one count ahead of the wrap.
                    w_pulse = (r_presc == c_PRE_TERM);
                    if (r_presc == c_TERM) begin
                        w_presc_clr = 1'b1;
                    end else begin
                        w_presc_inc = 1'b1;
                    end
                end
            end
            c_S_HALT: begin
                if (!halt_in && !run_in) begin
                    w_state_next = c_S_IDLE;
                end
            end
            default: begin
                w_state_next = c_S_IDLE;
            end
        endcase
    end

    // step_q resets high so a button held through reset release is not a press
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= c_S_IDLE;
            r_step_q <= 1'b1;
            r_presc  <= '0;
            r_cpu_en <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_step_q <= step_in;
            r_cpu_en <= w_pulse;
            if (w_presc_clr) begin
                r_presc <= '0;
            end else if (w_presc_inc) begin
                r_presc <= r_presc + c_PRESC_W'(1);
            end
        end
    end

    assign cpu_en = r_cpu_en;
    assign mode   = r_state;

`ifdef STEP_COUNT_EN
    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (w_pulse) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign step_count = r_count;
`else
    assign step_count = '0;
`endif

endmodule
`default_nettype wire
